// File: rtl/sine_pkg.sv
// Shared definitions for the sine NCO: quadrant codes, quarter-table generator
// and the cosine quadrant helper.
package sine_pkg;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam real PI = 3.14159265358979323846;

  // Half-sample offset keeps every entry non-zero and the fold symmetric.
  function automatic int qtable_entry(input int i, input int aw, input int dw);
    real amp;
    real ang;
    amp = real'((1 << (dw - 1)) - 1);
    ang = 2.0 * PI * (real'(i) + 0.5) / real'(1 << (aw + 2));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

  // Cosine leads sine by a quarter cycle.
  function automatic logic [1:0] cos_quad(input logic [1:0] q);
    return 2'(q + 2'd1);
  endfunction

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine table with quadrant folding; combinational signed output.
module sine_qlut
  import sine_pkg::*;
#(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
) (
  input  logic [AW+1:0]        ph,
  output logic signed [DW-1:0] val_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] tab [DEPTH];
  logic [1:0]    quad;
  logic [AW-1:0] idx;

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_tab
    localparam int ENTRY = qtable_entry(i, int'(AW), int'(DW));
    assign tab[i] = DW'(ENTRY);
  end

  // Mirror the index on odd quadrants, negate on the lower half-cycle.
  always_comb begin
    quad  = ph[AW+1:AW];
    idx   = ph[AW-1:0];
    val_c = '0;
    case (quad)
      QUAD_0: val_c = $signed(tab[idx]);
      QUAD_1: val_c = $signed(tab[~idx]);
      QUAD_2: val_c = -$signed(tab[idx]);
      QUAD_3: val_c = -$signed(tab[~idx]);
    endcase
  end

endmodule

// File: rtl/sine_nco.sv
// Numerically controlled oscillator: phase accumulator, offset stage and
// folded-table lookup producing simultaneous sine/cosine with a valid strobe.
module sine_nco
  import sine_pkg::*;
#(
  parameter int unsigned PW = 16,
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 en,
  input  logic [PW-1:0]        freq,
  input  logic [PW-1:0]        phase_off,
  input  logic                 sync_clr,
  output logic signed [DW-1:0] sin_out,
  output logic signed [DW-1:0] cos_out,
  output logic                 valid,
  output logic [PW-1:0]        acc
);

  localparam int unsigned PHW   = AW + 2;
  localparam int unsigned SHIFT = PW - PHW;

  if (PW < AW + 2 || DW < 2) begin : g_param_err
    $error("sine_nco: illegal parameters, need PW >= AW+2 and DW >= 2");
  end

  logic [PW-1:0]        acc_q, acc_d;
  logic [PHW-1:0]       p1_q, p1_d;
  logic                 v1_q, v1_d;
  logic                 valid_q, valid_d;
  logic signed [DW-1:0] sin_q, sin_d;
  logic signed [DW-1:0] cos_q, cos_d;
  logic signed [DW-1:0] sin_c, cos_c;
  logic [PHW-1:0]       cos_ph_c;

  assign cos_ph_c = {cos_quad(p1_q[PHW-1:AW]), p1_q[AW-1:0]};

  sine_qlut #(.AW(AW), .DW(DW)) u_sin_lut (
    .ph    (p1_q),
    .val_c (sin_c)
  );

  sine_qlut #(.AW(AW), .DW(DW)) u_cos_lut (
    .ph    (cos_ph_c),
    .val_c (cos_c)
  );

  // Stage 1 keeps only the table-index bits of acc+offset; the rest are truncated.
  always_comb begin
    acc_d   = acc_q;
    p1_d    = p1_q;
    v1_d    = en;
    valid_d = v1_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    if (sync_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + freq;
    end
    if (en) begin
      p1_d = PHW'((acc_q + phase_off) >> SHIFT);
    end
    if (v1_q) begin
      sin_d = sin_c;
      cos_d = cos_c;
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      acc_q   <= '0;
      p1_q    <= '0;
      v1_q    <= 1'b0;
      valid_q <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      p1_q    <= p1_d;
      v1_q    <= v1_d;
      valid_q <= valid_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign acc     = acc_q;
  assign valid   = valid_q;
  assign sin_out = sin_q;
  assign cos_out = cos_q;

endmodule

// File: doc/sine_nco.md
Name: sine_nco

Overview:
Parametrised numerically controlled oscillator. It is the successor to the fixed 8-bit, 256-entry one-shot sine lookup.
- Phase accumulator with programmable frequency tuning word and phase offset.
- Quarter-wave folded table, generated at elaboration for any width.
- Simultaneous sine and cosine outputs in two's complement, with a valid strobe.
- Feeds the DSP/arithmetic benchmarks as a tone source.

Parameters:
PW, 16, phase accumulator width in bits (PW >= AW+2)
AW, 6, quarter-table address bits; table depth 2**AW, full-cycle resolution 2**(AW+2)
DW, 8, signed output width (DW >= 2)

Ports:
clk  input  1  clock, rising edge
nreset  input  1  reset, synchronous, active-high (asserted = 1 resets on the next rising clk)
en  input  1  advance accumulator and launch one sample this cycle
freq  input  PW  tuning word added to the accumulator per enabled cycle
phase_off  input  PW  phase offset added to the accumulator value before lookup
sync_clr  input  1  clear accumulator to 0 (phase re-sync)
sin_out  output  DW  signed sine sample
cos_out  output  DW  signed cosine sample
valid  output  1  sin_out/cos_out hold a new sample this cycle
acc  output  PW  current accumulator value

Behaviour:
- Reset (nreset=1 at a clk edge): acc, both pipeline stages, sin_out, cos_out and valid go to 0. Reset overrides all other inputs. Reset mid-stream drops any in-flight samples; no valid is emitted for them.
- Accumulator:
  - When en=1: acc <= acc + freq, modulo 2**PW, wrapping silently.
  - When en=0: acc holds.
  - When sync_clr=1: acc <= 0, regardless of en. A sample launched in the same cycle uses the pre-clear acc.
- Stage 1, registered when en=1:
  - p1 <= acc + phase_off (mod 2**PW), using acc before this cycle's update.
  - v1 <= en.
- Fold:
  - ph = p1[PW-1 : PW-AW-2], quadrant q = ph[AW+1:AW], idx = ph[AW-1:0].
  - Cosine uses qc = q+1 (mod 4) with the same idx.
- Quarter table:
  - Q[i] = round((2**(DW-1)-1) * sin(2*pi*(i+0.5)/2**(AW+2))), for i in 0..2**AW-1.
  - The half-sample offset makes the folding exact and symmetric. No entry is 0, and max is 2**(DW-1)-1, so -2**(DW-1) is never produced.
- Quadrant mapping:
  - q=0: +Q[idx]
  - q=1: +Q[~idx]
  - q=2: -Q[idx]
  - q=3: -Q[~idx]
- Stage 2 (output):
  - Every cycle, valid <= v1.
  - sin_out/cos_out update only when v1=1 and otherwise hold their last value.
- Latency: en sampled at edge t gives valid=1 with the matching samples at edge t+2. Throughput is one sample per clk. en may toggle on any cycle; gaps propagate as valid=0 cycles.
- PW bits below the table index are truncated. No dithering or interpolation.
- Illegal parameters (PW < AW+2, DW < 2) stop elaboration with an error message.

Decomposition:
- Shared package sine_pkg holds:
  - qtable_entry(i, AW, DW), a constant function computing Q[i].
  - Quadrant constants QUAD_0..QUAD_3.
  - The helper for the cosine quadrant offset.
- Sub-module sine_qlut (params AW, DW): table generated via sine_pkg, input {q, idx}, combinational folded signed output. Instantiated twice (sin, cos) inside sine_nco; each instance is 30-60 lines.
- The top handles the accumulator, offset, pipeline regs and valid.

Test Plan (defaults PW=16, AW=6, DW=8; Q[0]=2, Q[63]=127):
- Reset: hold nreset=1 for 3 cycles with en=1, freq=0x1234 -> acc=0, valid=0, sin_out=0, cos_out=0 throughout. First valid appears exactly 2 cycles after the first en with nreset=0.
- Quadrant points: freq=0, phase_off in {0x0000, 0x4000, 0x8000, 0xC000}, en=1 -> (sin,cos) = (+2,+127), (+127,-2), (-2,-127), (-127,+2), two cycles after each phase_off change.
- Sweep and wrap: freq=0x0400, en=1 for 80 cycles -> acc steps by 0x0400 and wraps from 0xFC00 to 0x0000. Samples repeat with period 64, and sin[n]² + cos[n]² lies within ±2% of 127² for every sample. Symmetry checks: sin at phase p = -sin at p+0x8000, and cos at p = sin at p+0x4000, for each p in the sweep.
- en gaps: en pattern 1,0,0,1,1,0 -> valid pattern 0,0,1,0,0,1,1,0 on the output. acc advances only on the en cycles, and outputs hold during valid=0.
- sync_clr collision: acc=0x3000, freq=0x0100, en=1 and sync_clr=1 in the same cycle -> acc=0 next cycle. The sample launched that cycle uses phase 0x3000; the next sample uses phase 0x0000.
- Parametric: PW=24, AW=10, DW=16, phase_off=0x400000 -> sin_out=+32767 and cos_out=-Q[0] within tolerance. No -32768 value occurs over a full-cycle sweep with freq=0x001000.
